// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - instruction fetch stage with a direct-mapped instruction cache
module fetcher_icache #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);
  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  localparam logic [2:0] S_IDLE      = 3'b000;
  localparam logic [2:0] S_FETCHING  = 3'b001;
  localparam logic [2:0] S_FETCHED   = 3'b010;
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  logic [2:0]                       r_state;
  logic [2:0]                       w_next_state;
  logic [CACHE_LINES-1:0]           r_valid;
  logic [TAG_BITS-1:0]              r_tag  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_data [CACHE_LINES];
  logic                             r_req;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instr;
  logic [15:0]                      r_hit_count;
  logic [15:0]                      r_miss_count;

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic [IDX_BITS-1:0] w_fill_idx;
  logic                w_hit;
  logic                w_lookup;
  logic                w_fill;

  assign w_idx      = current_pc[IDX_BITS-1:0];
  assign w_tag      = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
  assign w_fill_idx = r_addr[IDX_BITS-1:0];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_lookup   = (r_state == S_IDLE) && (core_state == CORE_FETCH);
  assign w_fill     = (r_state == S_FETCHING) && mem_read_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_lookup) w_next_state = w_hit ? S_FETCHED : S_FETCHING;
      S_FETCHING: if (mem_read_ready) w_next_state = S_FETCHED;
      S_FETCHED:  if (core_state == CORE_DECODE) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fetcher_state    = r_state;
    mem_read_valid   = r_req;
    mem_read_address = r_addr;
    instruction      = r_instr;
    hit_count        = r_hit_count;
    miss_count       = r_miss_count;
  end

  // Flush takes priority over a coincident fill so the filled line stays invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= '0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_instr      <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (cache_flush)  r_valid <= '0;
      else if (w_fill)  r_valid[w_fill_idx] <= 1'b1;

      if (w_lookup && w_hit) begin
        r_instr <= r_data[w_idx];
        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end else if (w_lookup) begin
        r_req  <= 1'b1;
        r_addr <= current_pc;
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end else if (w_fill) begin
        r_req   <= 1'b0;
        r_instr <= mem_read_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= r_addr[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
      r_data[w_fill_idx] <= mem_read_data;
    end
  end
endmodule

// File: tb/tb_fetcher_icache.sv
// tb/tb_fetcher_icache.sv - scoreboard bench for fetcher_icache against a cache/memory model
module tb_fetcher_icache;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        cache_flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  fetcher_icache dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .cache_flush(cache_flush), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
    .instruction(instruction), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] hits;
    logic [15:0] misses;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [256];
  logic [7:0]  resident [int];
  int          m_hits;
  int          m_misses;
  int          total = 0;
  int          bad = 0;
  logic        prev_fetched = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every entry into FETCHED must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("state_legal", {31'd0, fetcher_state > 3'b010}, 32'd0);
      if (fetcher_state == 3'b010 && !prev_fetched) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_fetched actual=%h required=none", instruction);
        end else begin
          mon_e = sb.pop_front();
          check("instruction", {16'd0, instruction}, {16'd0, mon_e.instr});
          check("hit_count", {16'd0, hit_count}, {16'd0, mon_e.hits});
          check("miss_count", {16'd0, miss_count}, {16'd0, mon_e.misses});
        end
      end
    end
    prev_fetched <= (fetcher_state == 3'b010);
  end

  // Called at a negedge with the fetcher idle.
  task automatic do_fetch(input logic [7:0] pc, input int lat, input bit flush_start,
                          input bit flush_ready);
    int   idx;
    bit   hit;
    exp_t e;
    idx = int'(pc % 8);
    hit = resident.exists(idx) && (resident[idx] == pc);
    if (hit) begin if (m_hits < 65535) m_hits++; end
    else     begin if (m_misses < 65535) m_misses++; end
    e.instr = mem[pc]; e.hits = 16'(m_hits); e.misses = 16'(m_misses);
    sb.push_back(e);
    if (flush_start) resident.delete();

    current_pc  = pc;
    core_state  = 3'b001;
    cache_flush = flush_start;
    @(negedge clk);
    cache_flush = 1'b0;
    if (hit) begin
      check("hit_latency", {29'd0, fetcher_state}, 32'd2);
      check("hit_no_request", {31'd0, mem_read_valid}, 32'd0);
    end else begin
      check("miss_state", {29'd0, fetcher_state}, 32'd1);
      check("miss_request", {23'd0, mem_read_valid, mem_read_address}, {23'd0, 1'b1, pc});
      for (int i = 0; i < lat; i++) begin
        current_pc = 8'($urandom);
        @(negedge clk);
        check("request_held", {23'd0, mem_read_valid, mem_read_address}, {23'd0, 1'b1, pc});
      end
      mem_read_ready = 1'b1;
      mem_read_data  = mem[pc];
      cache_flush    = flush_ready;
      @(negedge clk);
      mem_read_ready = 1'b0;
      mem_read_data  = 16'($urandom);
      cache_flush    = 1'b0;
      check("fill_state", {29'd0, fetcher_state}, 32'd2);
      check("fill_req_drop", {31'd0, mem_read_valid}, 32'd0);
      if (flush_ready) resident.delete();
      else             resident[idx] = pc;
    end
    core_state = 3'b010;
    @(negedge clk);
    check("decode_to_idle", {29'd0, fetcher_state}, 32'd0);
    core_state = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'h3A21;
    m_hits = 0; m_misses = 0;
    reset = 1'b0; core_state = 3'b000; current_pc = 8'h00; cache_flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_state", {29'd0, fetcher_state}, 32'd0);
    check("reset_counts", {hit_count, miss_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    do_fetch(8'h05, 3, 0, 0);
    do_fetch(8'h05, 0, 0, 0);
    check("hit_one", {16'd0, hit_count}, 32'd1);
    do_fetch(8'h0D, 2, 0, 0);
    do_fetch(8'h05, 1, 0, 0);
    check("conflict_misses", {16'd0, miss_count}, 32'd3);
    do_fetch(8'h02, 2, 0, 1);
    do_fetch(8'h02, 1, 0, 0);
    check("flush_fill_misses", {16'd0, miss_count}, 32'd5);

    for (int n = 0; n < 250; n++) begin
      do_fetch(8'($urandom_range(0, 23)), int'($urandom_range(0, 4)),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
    end

    do_fetch(8'h07, 1, 0, 0);
    do_fetch(8'h07, 0, 0, 0);
    force dut.r_hit_count = 16'hFFFD;
    #1 release dut.r_hit_count;
    m_hits = 16'hFFFD;
    for (int k = 0; k < 3; k++) do_fetch(8'h07, 0, 0, 0);
    check("hit_saturated", {16'd0, hit_count}, 32'h0000FFFF);
    check("miss_unaffected", {16'd0, miss_count}, 32'(m_misses));

    current_pc = 8'hA0; core_state = 3'b001;
    @(negedge clk);
    check("pre_reset_req", {31'd0, mem_read_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_req_drop", {31'd0, mem_read_valid}, 32'd0);
    check("async_state", {29'd0, fetcher_state}, 32'd0);
    check("async_instr", {16'd0, instruction}, 32'd0);
    check("async_counts", {hit_count, miss_count}, 32'd0);
    core_state = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    @(negedge clk);
    mem_read_ready = 1'b0;
    @(negedge clk);
    check("ready_ignored_state", {29'd0, fetcher_state}, 32'd0);
    check("ready_ignored_instr", {16'd0, instruction}, 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetcher_icache.md
Name: fetcher_icache

Overview:
- Per-core instruction fetch stage sitting directly upstream of the core scheduler; drives fetcher_state, which the scheduler polls in its FETCH state.
- Adds a small direct-mapped instruction cache in front of the program-memory controller channel, so loops hit in 1 cycle instead of a full memory round trip.
- Holds the fetched instruction stable for the decoder until the scheduler advances to DECODE.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program address width (matches current_pc)
PROGRAM_MEM_DATA_BITS, 16, instruction width
CACHE_LINES, 8, number of direct-mapped lines, one instruction per line; power of two, 2..64

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset (0 = reset)
core_state  input  3  scheduler state; FETCH=3'b001, DECODE=3'b010
current_pc  input  PROGRAM_MEM_ADDR_BITS  PC to fetch
cache_flush  input  1  invalidate all lines (pulsed by dispatcher at kernel launch)
mem_read_valid  output  1  program-memory read request
mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address
mem_read_ready  input  1  response valid / request complete
mem_read_data  input  PROGRAM_MEM_DATA_BITS  response instruction
fetcher_state  output  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010
instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction
hit_count  output  16  saturating cache-hit counter
miss_count  output  16  saturating cache-miss counter

Behaviour:
- Reset (reset=0, async): fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, hit_count=0, miss_count=0, all valid bits cleared. Outstanding memory responses are dropped. Normal operation resumes on the first clk edge after reset returns to 1.
- Cache organisation:
  - index = current_pc[log2(CACHE_LINES)-1:0]; tag = remaining upper PC bits.
  - Per line: valid bit, tag, data.
  - Lookup is combinational on current_pc.
- IDLE: acts only when core_state==FETCH.
  - Hit (valid & tag match): instruction<=line data; hit_count++; go FETCHED. Latency is 1 cycle. No memory request is issued.
  - Miss: mem_read_valid<=1; mem_read_address<=current_pc; miss_count++; go FETCHING.
- FETCHING:
  - mem_read_valid stays 1 and mem_read_address stays stable until mem_read_ready=1 is sampled.
  - On that edge: instruction<=mem_read_data; write line (valid=1, tag, data); mem_read_valid<=0; go FETCHED.
  - Total miss latency is 1 + memory latency.
- FETCHED: instruction holds. When core_state==DECODE, go IDLE. No new fetch is accepted while in FETCHED.
- mem_read_ready is ignored in any state other than FETCHING.
- cache_flush:
  - Clears all valid bits on the edge it is sampled, in any state.
  - If it coincides with a fill, flush wins and the line stays invalid, but instruction is still delivered and the FSM still goes FETCHED.
  - A flush never aborts an in-flight request.
  - If it coincides with a hit in IDLE, the hit completes normally from pre-flush contents.
- Counters saturate at 16'hFFFF and never wrap.
- current_pc is sampled only in IDLE. Changes to it during FETCHING or FETCHED have no effect.
- fetcher_state encodings 3'b011–3'b111 are never produced.

Test Plan:
1. Reset low mid-FETCHING with mem_read_valid=1 -> mem_read_valid drops to 0 without waiting for clk; fetcher_state=000, instruction=0, counters=0; a later ready pulse is ignored.
2. Cold miss: pc=8'h05, core_state=FETCH, memory returns 16'h3A21 after 3 cycles -> valid with address 8'h05 until ready; fetcher_state=010 the cycle after ready; instruction=16'h3A21; miss_count=1; DECODE returns fetcher_state to 000.
3. Re-fetch pc=8'h05 -> FETCHED 1 cycle after FETCH; mem_read_valid never asserted; instruction=16'h3A21; hit_count=1.
4. Conflict: fetch pc=8'h0D (same index 5, different tag) -> miss, line replaced; then fetching 8'h05 misses again; miss_count=3.
5. cache_flush pulsed on the same edge as ready for pc=8'h02 -> instruction delivered; next fetch of 8'h02 misses.
6. Force hit_count to 16'hFFFF via repeated hits on one pc (preload or a long loop) -> one more hit leaves it at 16'hFFFF; miss_count unaffected.
